// File: rtl/ctr_stream_cipher_mb.sv
// Multi-byte counter-mode stream cipher: lane i of each beat is XORed with S(cb+i),
// results queue in a small output FIFO so downstream backpressure never stalls the keystream.
module ctr_stream_cipher_mb #(
    parameter int LANES      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               key_in,
    input  logic [7:0]         key,
    input  logic               din_valid,
    output logic               din_ready,
    input  logic [8*LANES-1:0] din_data,
    input  logic [LANES-1:0]   din_keep,
    output logic               dout_valid,
    input  logic               dout_ready,
    output logic [8*LANES-1:0] dout_data,
    output logic [LANES-1:0]   dout_keep,
    output logic               keyed
);

    // state | meaning
    // NOKEY | no key since reset, input refused
    // RUN   | keyed, beats accepted while FIFO has room
    typedef enum logic {NOKEY, RUN} state_t;

    localparam int PW = $clog2(FIFO_DEPTH);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] popcount(input logic [LANES-1:0] v);
        logic [7:0] n;
        n = 8'h00;
        for (int i = 0; i < LANES; i++) begin
            n = n + 8'(v[i]);
        end
        return n;
    endfunction

    state_t              state;
    state_t              state_nxt;
    logic [7:0]          cb;
    logic [PW:0]         count;
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic                push;
    logic                pop;
    logic [8*LANES-1:0]  enc_data;
    logic [8*LANES-1:0]  mem_data [FIFO_DEPTH];
    logic [LANES-1:0]    mem_keep [FIFO_DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= NOKEY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        keyed     = 1'b0;
        case (state)
            NOKEY: begin
                if (key_in) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                keyed = 1'b1;
            end
            default: state_nxt = NOKEY;
        endcase
    end

    // No pass-through on a full FIFO: a same-cycle pop does not open a slot.
    assign din_ready  = keyed && !key_in && (count < (PW+1)'(FIFO_DEPTH));
    assign dout_valid = (count != '0);
    assign push       = din_valid && din_ready;
    assign pop        = dout_valid && dout_ready;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [7:0] ks;
        assign ks = SBOX[cb + 8'(g)];
        assign enc_data[8*g +: 8] = din_keep[g] ? (din_data[8*g +: 8] ^ ks) : 8'h00;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cb <= 8'h00;
        end else if (key_in) begin
            cb <= key;
        end else if (push) begin
            cb <= cb + popcount(din_keep);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= enc_data;
            mem_keep[wr_ptr] <= din_keep;
        end
    end

    // Storage is not reset, so the outputs are forced to zero while the FIFO is empty.
    assign dout_data = dout_valid ? mem_data[rd_ptr] : '0;
    assign dout_keep = dout_valid ? mem_keep[rd_ptr] : '0;

endmodule

// File: tb/tb_ctr_stream_cipher_mb.sv
// Self-checking bench for ctr_stream_cipher_mb: vector table plus scoreboard fed by an
// independent GF(2^8) sbox model and a bench-side counter-block model.
module tb_ctr_stream_cipher_mb;

    logic        clk;
    logic        rst_n;
    logic        key_in;
    logic [7:0]  key;
    logic        din_valid;
    logic        din_ready;
    logic [31:0] din_data;
    logic [3:0]  din_keep;
    logic        dout_valid;
    logic        dout_ready;
    logic [31:0] dout_data;
    logic [3:0]  dout_keep;
    logic        keyed;

    ctr_stream_cipher_mb #(.LANES(4), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_in     (key_in),
        .key        (key),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .din_data   (din_data),
        .din_keep   (din_keep),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_data  (dout_data),
        .dout_keep  (dout_keep),
        .keyed      (keyed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
    } beat_t;

    typedef struct {
        bit          load;
        logic [7:0]  k;
        logic [31:0] data;
        logic [3:0]  keep;
        logic [31:0] exp;
    } vec_t;

    int    checks = 0;
    int    errors = 0;
    logic [7:0] cb_m = 8'h00;
    bit    cap_en = 1'b0;
    beat_t sb_q[$];
    beat_t got_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] p;
        a = a_in;
        b = b_in;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    function automatic logic [7:0] s_model(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h00;
        for (int y = 1; y < 256; y++) begin
            if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
        end
        return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] model_beat(input logic [31:0] d, input logic [3:0] kp,
                                               input logic [7:0] c);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            if (kp[i]) r[8*i +: 8] = d[8*i +: 8] ^ s_model(c + 8'(i));
        end
        return r;
    endfunction

    // Scoreboard: model pushes on every input transfer, compares on every output transfer.
    always @(negedge clk) begin
        if (rst_n) begin
            if (key_in) cb_m = key;
            if (dout_valid && dout_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_output", dout_data, 32'hxxxxxxxx);
                end else begin
                    beat_t e;
                    e = sb_q.pop_front();
                    check("sb_data", dout_data, e.data);
                    check("sb_keep", 32'(dout_keep), 32'(e.keep));
                end
                if (cap_en) got_q.push_back('{data: dout_data, keep: dout_keep});
            end
            if (din_valid && din_ready) begin
                sb_q.push_back('{data: model_beat(din_data, din_keep, cb_m), keep: din_keep});
                for (int i = 0; i < 4; i++) cb_m = cb_m + 8'(din_keep[i]);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && din_valid)
            assert (((din_keep + 4'd1) & din_keep) == 4'd0) else $error("non-contiguous din_keep %b", din_keep);
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // All tasks start and end one time unit after a rising edge.
    task automatic load_key(input logic [7:0] k);
        key_in = 1'b1;
        key    = k;
        @(posedge clk); #1;
        key_in = 1'b0;
    endtask

    task automatic offer(input logic [31:0] d, input logic [3:0] kp, input int maxc, output bit ok);
        din_valid = 1'b1;
        din_data  = d;
        din_keep  = kp;
        ok = 1'b0;
        for (int c = 0; c < maxc && !ok; c++) begin
            @(negedge clk);
            if (din_ready) ok = 1'b1;
            @(posedge clk); #1;
        end
        din_valid = 1'b0;
    endtask

    task automatic drain(input int maxc);
        int c;
        c = 0;
        while ((sb_q.size() != 0 || dout_valid) && c < maxc) begin
            @(posedge clk); #1;
            c++;
        end
        check("drain_done", 32'(sb_q.size()), 32'd0);
    endtask

    vec_t  vecs[10];
    beat_t saved[3];
    bit    ok;
    int    acc;
    logic [31:0] held;

    initial begin
        vecs[0] = '{1'b1, 8'h10, 32'h00000000, 4'hF, 32'h7dc982ca};
        vecs[1] = '{1'b0, 8'h00, 32'h00000000, 4'h1, 32'h000000fa};
        vecs[2] = '{1'b1, 8'hFE, 32'h00000000, 4'hF, 32'h7c6316bb};
        vecs[3] = '{1'b0, 8'h00, 32'h00000000, 4'h3, 32'h00007b77};
        vecs[4] = '{1'b0, 8'h00, 32'h00000000, 4'h1, 32'h000000f2};
        vecs[5] = '{1'b0, 8'h00, 32'hdeadbeef, 4'h0, 32'h00000000};
        vecs[6] = '{1'b0, 8'h00, 32'h00000000, 4'h1, 32'h0000006b};
        vecs[7] = '{1'b1, 8'h00, 32'hffffffff, 4'h3, 32'h0000839c};
        vecs[8] = '{1'b1, 8'h20, 32'h12345678, 4'h1, 32'h000000cf};
        vecs[9] = '{1'b1, 8'h40, 32'ha5a5a5a5, 4'h7, 32'h008926ac};

        rst_n = 1'b0; key_in = 1'b0; key = 8'h00; din_valid = 1'b0;
        din_data = '0; din_keep = '0; dout_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_dout_valid", 32'(dout_valid), 32'd0);
        check("rst_dout_data", dout_data, 32'd0);
        check("rst_dout_keep", 32'(dout_keep), 32'd0);
        check("rst_din_ready", 32'(din_ready), 32'd0);
        check("rst_keyed", 32'(keyed), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // No key: input must be refused.
        din_valid = 1'b1; din_data = 32'haaaaaaaa; din_keep = 4'hF;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("nokey_din_ready", 32'(din_ready), 32'd0);
            check("nokey_dout_valid", 32'(dout_valid), 32'd0);
            @(posedge clk); #1;
        end
        din_valid = 1'b0;
        check("nokey_sb_empty", 32'(sb_q.size()), 32'd0);

        // Vector table: one beat each, visible the cycle after acceptance.
        for (int v = 0; v < 10; v++) begin
            if (vecs[v].load) begin
                load_key(vecs[v].k);
                check("keyed_after_key", 32'(keyed), 32'd1);
            end
            offer(vecs[v].data, vecs[v].keep, 5, ok);
            check("vec_accepted", 32'(ok), 32'd1);
            check("vec_dout_valid", 32'(dout_valid), 32'd1);
            check("vec_dout_data", dout_data, vecs[v].exp);
            check("vec_dout_keep", 32'(dout_keep), 32'(vecs[v].keep));
            drain(10);
        end

        // Backpressure: only FIFO_DEPTH beats fit, head stays stable while stalled.
        dout_ready = 1'b0;
        load_key(8'h33);
        acc = 0;
        for (int b = 0; b < 6; b++) begin
            offer(32'h01020304 * (b + 1), 4'hF, 3, ok);
            if (ok) acc++;
        end
        check("full_accepted", acc, 32'd4);
        @(negedge clk);
        check("full_din_ready", 32'(din_ready), 32'd0);
        held = dout_data;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("stall_stable", dout_data, held);
        end
        @(posedge clk); #1;
        dout_ready = 1'b1;
        drain(20);

        // Key reload while beats are queued: old beats keep the old keystream.
        dout_ready = 1'b0;
        load_key(8'h44);
        offer(32'hcafef00d, 4'hF, 3, ok);
        check("k5_beat0", 32'(ok), 32'd1);
        offer(32'h0badbeef, 4'h3, 3, ok);
        check("k5_beat1", 32'(ok), 32'd1);
        key_in = 1'b1; key = 8'h80;
        din_valid = 1'b1; din_data = 32'h11223344; din_keep = 4'hF;
        @(negedge clk);
        check("keyin_blocks_input", 32'(din_ready), 32'd0);
        @(posedge clk); #1;
        key_in = 1'b0;
        offer(32'h11223344, 4'hF, 3, ok);
        check("k5_beat2", 32'(ok), 32'd1);
        got_q.delete();
        cap_en = 1'b1;
        dout_ready = 1'b1;
        drain(20);
        cap_en = 1'b0;
        check("k5_count", 32'(got_q.size()), 32'd3);
        if (got_q.size() == 3) check("k5_new_key_data", got_q[2].data, 32'hfd313f89);

        // Reset with beats in flight.
        dout_ready = 1'b0;
        for (int b = 0; b < 3; b++) offer(32'h5a5a0000 + b, 4'hF, 3, ok);
        check("pre_rst_valid", 32'(dout_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_dout_valid", 32'(dout_valid), 32'd0);
        check("midrst_keyed", 32'(keyed), 32'd0);
        check("midrst_din_ready", 32'(din_ready), 32'd0);
        check("midrst_dout_data", dout_data, 32'd0);
        sb_q.delete();
        cb_m = 8'h00;
        @(posedge clk); #1;
        rst_n = 1'b1;
        dout_ready = 1'b1;
        @(posedge clk); #1;
        check("postrst_dout_valid", 32'(dout_valid), 32'd0);
        check("postrst_din_ready", 32'(din_ready), 32'd0);

        // Round trip: re-encrypting ciphertext with the same key restores plaintext.
        saved[0] = '{data: 32'h48656c6c, keep: 4'hF};
        saved[1] = '{data: 32'h6f20776f, keep: 4'hF};
        saved[2] = '{data: 32'h00006c64, keep: 4'h3};
        load_key(8'h55);
        got_q.delete();
        cap_en = 1'b1;
        for (int b = 0; b < 3; b++) offer(saved[b].data, saved[b].keep, 5, ok);
        drain(20);
        check("rt_pass1_count", 32'(got_q.size()), 32'd3);
        if (got_q.size() == 3) begin
            beat_t ct[3];
            for (int b = 0; b < 3; b++) ct[b] = got_q[b];
            got_q.delete();
            load_key(8'h55);
            for (int b = 0; b < 3; b++) offer(ct[b].data, ct[b].keep, 5, ok);
            drain(20);
            check("rt_pass2_count", 32'(got_q.size()), 32'd3);
            if (got_q.size() == 3)
                for (int b = 0; b < 3; b++) check("rt_plaintext", got_q[b].data, saved[b].data);
        end
        cap_en = 1'b0;

        check("final_sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
